// File: rtl/mul_seq_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mul_seq_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        CALC,
        OUT_LO,
        OUT_HI
    } mul_seq_state_t;

    localparam int DEF_WIDTH = 8;

    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int PROD_W = prod_w(DEF_WIDTH);
    localparam int CNT_W  = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/mul_seq_datapath.sv
// Operand registers, accumulator and bit counter of the shift-add multiplier.
// MUL_SEQ_APPROX_EN adds the truncated-addend path selected by the latched approx bit.
module mul_seq_datapath
    import mul_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TRUNC_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_a_i,
    input  logic                 load_b_i,
    input  logic                 calc_en_i,
    input  logic [WIDTH-1:0]     data_i,
    input  logic                 approx_i,
    output logic [2*WIDTH-1:0]   product_o,
    output logic                 cnt_last_o
);

    localparam int PW = prod_w(WIDTH);
    localparam int CW = cnt_w(WIDTH);

    logic [WIDTH-1:0] a_q, b_q;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    shifted, addend;
    logic [CW-1:0]    cnt_q, cnt_d;

    assign shifted = {{WIDTH{1'b0}}, a_q} << cnt_q;

`ifdef MUL_SEQ_APPROX_EN
    localparam logic [PW-1:0] TRUNC_MASK = ~((PW'(1) << TRUNC_BITS) - PW'(1));
    logic approx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            approx_q <= 1'b0;
        else if (load_b_i)
            approx_q <= approx_i;
    end

    // Dropping low columns of every addend keeps the result at or below the exact product.
    assign addend = approx_q ? (shifted & TRUNC_MASK) : shifted;
`else
    logic unused_approx;
    assign unused_approx = approx_i;
    assign addend        = shifted;
`endif

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (load_b_i) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (calc_en_i) begin
            if (b_q[cnt_q])
                acc_d = acc_q + addend;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            if (load_a_i)
                a_q <= data_i;
            if (load_b_i)
                b_q <= data_i;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign product_o  = acc_q;
    assign cnt_last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mul_seq_core.sv
// Sequential shift-add multiplier: two operand beats in, two product beats out (low first).
// Optional truncated multiply is compiled in with MUL_SEQ_APPROX_EN.
module mul_seq_core
    import mul_seq_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TRUNC_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    mul_seq_state_t state_q, state_d;

    logic               load_a, load_b, calc_en, cnt_last;
    logic [2*WIDTH-1:0] product;

    mul_seq_datapath #(
        .WIDTH      (WIDTH),
        .TRUNC_BITS (TRUNC_BITS)
    ) u_datapath (
        .clk        (clk),
        .rst        (rst),
        .load_a_i   (load_a),
        .load_b_i   (load_b),
        .calc_en_i  (calc_en),
        .data_i     (in_data),
        .approx_i   (approx),
        .product_o  (product),
        .cnt_last_o (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= LOAD_A;
        else
            state_q <= state_d;
    end

    // in_ready depends on state alone so no path exists from out_ready or in_valid.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        load_a    = 1'b0;
        load_b    = 1'b0;
        calc_en   = 1'b0;
        unique case (state_q)
            LOAD_A: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_a  = 1'b1;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_b  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                calc_en = 1'b1;
                if (cnt_last)
                    state_d = OUT_LO;
            end
            OUT_LO: begin
                out_valid = 1'b1;
                out_data  = product[WIDTH-1:0];
                if (out_ready)
                    state_d = OUT_HI;
            end
            OUT_HI: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = product[2*WIDTH-1:WIDTH];
                if (out_ready)
                    state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
    end

    assign busy = (state_q != LOAD_A);

endmodule

// File: tb/tb_mul_seq_core.sv
// Directed self-checking bench for mul_seq_core at WIDTH=8, TRUNC_BITS=4.
module tb_mul_seq_core;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       approx;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    mul_seq_core #(
        .WIDTH      (8),
        .TRUNC_BITS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .approx    (approx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic ap);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        approx   = ap;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50)
            check("send_timeout", 32'(n), 32'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, output int edges);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!out_valid) begin
                check({tag, "_calc_in_ready"}, 32'(in_ready), 32'(0));
                check({tag, "_calc_busy"}, 32'(busy), 32'(1));
            end
        end while (!out_valid && n < 40);
        edges = n - 1;
    endtask

    task automatic run(input logic [7:0] a, input logic [7:0] b, input logic ap,
                       input logic [7:0] lo, input logic [7:0] hi, input string tag);
        int edges;
        out_ready = 1'b1;
        send(a, 1'b0);
        send(b, ap);
        wait_valid(tag, edges);
        check({tag, "_latency"}, 32'(edges), 32'(8));
        check({tag, "_lo"}, 32'(out_data), 32'(lo));
        check({tag, "_lo_last"}, 32'(out_last), 32'(0));
        @(negedge clk);
        check({tag, "_hi_valid"}, 32'(out_valid), 32'(1));
        check({tag, "_hi"}, 32'(out_data), 32'(hi));
        check({tag, "_hi_last"}, 32'(out_last), 32'(1));
        check({tag, "_hi_in_ready"}, 32'(in_ready), 32'(0));
        @(negedge clk);
        check({tag, "_idle_valid"}, 32'(out_valid), 32'(0));
        check({tag, "_idle_in_ready"}, 32'(in_ready), 32'(1));
        check({tag, "_idle_busy"}, 32'(busy), 32'(0));
    endtask

    logic [7:0] seq_in  [4] = '{8'd2, 8'd3, 8'd4, 8'd5};
    logic [8:0] seq_exp [4] = '{9'h006, 9'h100, 9'h014, 9'h100};
    logic [8:0] got[$];

    initial begin
        int edges;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        approx    = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_out_data", 32'(out_data), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;
        @(negedge clk);

        run(8'd13, 8'd11, 1'b0, 8'h8F, 8'h00, "m13x11");
        run(8'd255, 8'd255, 1'b0, 8'h01, 8'hFE, "m255x255");
`ifdef MUL_SEQ_APPROX_EN
        run(8'd255, 8'd255, 1'b1, 8'hD0, 8'hFD, "m255x255_approx");
`else
        run(8'd255, 8'd255, 1'b1, 8'h01, 8'hFE, "m255x255_approx_off");
`endif
        run(8'd0, 8'd200, 1'b0, 8'h00, 8'h00, "m0x200");
        run(8'd128, 8'd2, 1'b0, 8'h00, 8'h01, "m128x2");

        // Backpressure in OUT_LO with ignored operand pulses.
        out_ready = 1'b0;
        send(8'd7, 1'b0);
        send(8'd9, 1'b0);
        wait_valid("bp", edges);
        check("bp_latency", 32'(edges), 32'(8));
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", 32'(out_valid), 32'(1));
            check("bp_hold_data", 32'(out_data), 32'(8'h3F));
            check("bp_hold_last", 32'(out_last), 32'(0));
            check("bp_hold_in_ready", 32'(in_ready), 32'(0));
            in_valid = k[0];
            in_data  = 8'hAA;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_lo", 32'(out_data), 32'(8'h3F));
        @(negedge clk);
        check("bp_hi", 32'(out_data), 32'(8'h00));
        check("bp_hi_last", 32'(out_last), 32'(1));
        @(negedge clk);
        check("bp_idle_valid", 32'(out_valid), 32'(0));
        run(8'd2, 8'd2, 1'b0, 8'h04, 8'h00, "after_bp");

        // Reset on the fourth CALC cycle.
        send(8'd6, 1'b0);
        send(8'd7, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        check("midrst_busy", 32'(busy), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_in_ready", 32'(in_ready), 32'(1));
        check("postrst_out_valid", 32'(out_valid), 32'(0));
        run(8'd3, 8'd5, 1'b0, 8'h0F, 8'h00, "m3x5_after_rst");

        // Back-to-back transactions with in_valid held high.
        out_ready = 1'b1;
        got.delete();
        fork
            begin
                int i;
                int n;
                i = 0;
                n = 0;
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = seq_in[0];
                while (i < 4 && n < 200) begin
                    if (in_ready) begin
                        @(posedge clk);
                        i++;
                        #1;
                        if (i < 4)
                            in_data = seq_in[i];
                    end else begin
                        @(posedge clk);
                    end
                    n++;
                    @(negedge clk);
                end
                in_valid = 1'b0;
                check("b2b_driver_beats", 32'(i), 32'(4));
            end
            begin
                int n;
                n = 0;
                while (got.size() < 4 && n < 200) begin
                    @(negedge clk);
                    if (out_valid)
                        got.push_back({out_last, out_data});
                    n++;
                end
            end
        join
        check("b2b_count", 32'(got.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            check($sformatf("b2b_beat%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF,
                  32'(seq_exp[i]));
        @(negedge clk);
        check("b2b_idle_in_ready", 32'(in_ready), 32'(1));
        check("b2b_idle_valid", 32'(out_valid), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
